// File: rtl/wbu2idu_if.sv
// Bus bundle between WBU, the wbu2idu return buffer and the IDU register-file port.
// Shared width macros are defined here (guarded) so every file sees the same values.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_INIT
`define ADDR_INIT 32'h8000_0000
`endif
`ifndef DATA_ZERO
`define DATA_ZERO 32'h0000_0000
`endif

interface wbu2idu_if #(
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned CNT_WIDTH = $clog2(DEPTH) + 1
);
   logic                   i_wbu_valid;
   logic                   o_w2i_ready;
   logic [`ADDR_WIDTH-1:0] i_wbu_pc;
   logic                   i_wbu_gpr_wr_en;
   logic [`GPRS_WIDTH-1:0] i_wbu_gpr_rd_id;
   logic [`DATA_WIDTH-1:0] i_wbu_gpr_wr_data;
   logic                   o_w2i_valid;
   logic                   i_idu_ready;
   logic [`ADDR_WIDTH-1:0] o_w2i_pc;
   logic                   o_w2i_gpr_wr_en;
   logic [`GPRS_WIDTH-1:0] o_w2i_gpr_rd_id;
   logic [`DATA_WIDTH-1:0] o_w2i_gpr_wr_data;
   logic [`GPRS_WIDTH-1:0] i_idu_rs1_id;
   logic [`GPRS_WIDTH-1:0] i_idu_rs2_id;
   logic                   o_w2i_rs1_hit;
   logic [`DATA_WIDTH-1:0] o_w2i_rs1_data;
   logic                   o_w2i_rs2_hit;
   logic [`DATA_WIDTH-1:0] o_w2i_rs2_data;
   logic [CNT_WIDTH-1:0]   o_w2i_count;

   // Buffer side
   modport slave (
      input  i_wbu_valid, i_wbu_pc, i_wbu_gpr_wr_en, i_wbu_gpr_rd_id, i_wbu_gpr_wr_data,
      input  i_idu_ready, i_idu_rs1_id, i_idu_rs2_id,
      output o_w2i_ready, o_w2i_valid, o_w2i_pc, o_w2i_gpr_wr_en, o_w2i_gpr_rd_id,
      output o_w2i_gpr_wr_data, o_w2i_rs1_hit, o_w2i_rs1_data, o_w2i_rs2_hit,
      output o_w2i_rs2_data, o_w2i_count
   );

   // WBU / IDU side
   modport master (
      output i_wbu_valid, i_wbu_pc, i_wbu_gpr_wr_en, i_wbu_gpr_rd_id, i_wbu_gpr_wr_data,
      output i_idu_ready, i_idu_rs1_id, i_idu_rs2_id,
      input  o_w2i_ready, o_w2i_valid, o_w2i_pc, o_w2i_gpr_wr_en, o_w2i_gpr_rd_id,
      input  o_w2i_gpr_wr_data, o_w2i_rs1_hit, o_w2i_rs1_data, o_w2i_rs2_hit,
      input  o_w2i_rs2_data, o_w2i_count
   );
endinterface

// File: rtl/wbu2idu.sv
// Writeback-to-decode GPR write return buffer: in-order FIFO with optional rs1/rs2 bypass.
// Optional feature macro: W2I_BYPASS_EN (bypass lookup; tied off when undefined).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_INIT
`define ADDR_INIT 32'h8000_0000
`endif
`ifndef DATA_ZERO
`define DATA_ZERO 32'h0000_0000
`endif

module wbu2idu #(
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned CNT_WIDTH = $clog2(DEPTH) + 1
) (
   input  logic        i_sys_clk,
   input  logic        i_sys_rst_n,
   wbu2idu_if.slave    bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]       r_rptr;
   logic [PTR_W-1:0]       r_wptr;
   logic [CNT_WIDTH-1:0]   r_count;
   logic [`ADDR_WIDTH-1:0] r_pc   [DEPTH];
   logic [`GPRS_WIDTH-1:0] r_rd   [DEPTH];
   logic [`DATA_WIDTH-1:0] r_data [DEPTH];

   logic w_not_full;
   logic w_valid;
   logic w_enq;
   logic w_store;
   logic w_deq;

   assign w_not_full = (r_count < CNT_WIDTH'(DEPTH));
   assign w_valid    = (r_count != '0);
   assign w_enq      = bus.i_wbu_valid & bus.o_w2i_ready;
   // Requests that write nothing (no enable, or x0) are consumed without occupying an entry
   assign w_store    = w_enq & bus.i_wbu_gpr_wr_en & (bus.i_wbu_gpr_rd_id != '0);
   assign w_deq      = w_valid & bus.i_idu_ready;

   assign bus.o_w2i_ready       = i_sys_rst_n & w_not_full;
   assign bus.o_w2i_valid       = w_valid;
   assign bus.o_w2i_pc          = r_pc[r_rptr];
   assign bus.o_w2i_gpr_wr_en   = w_valid;
   assign bus.o_w2i_gpr_rd_id   = r_rd[r_rptr];
   assign bus.o_w2i_gpr_wr_data = r_data[r_rptr];
   assign bus.o_w2i_count       = r_count;

   // FIFO storage, pointers and occupancy
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_pc[i]   <= `ADDR_INIT;
            r_rd[i]   <= '0;
            r_data[i] <= `DATA_ZERO;
         end
      end else begin
         if (w_store) begin
            r_pc[r_wptr]   <= bus.i_wbu_pc;
            r_rd[r_wptr]   <= bus.i_wbu_gpr_rd_id;
            r_data[r_wptr] <= bus.i_wbu_gpr_wr_data;
            r_wptr         <= r_wptr + PTR_W'(1);
         end
         if (w_deq) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         if (w_store && !w_deq) begin
            r_count <= r_count + CNT_WIDTH'(1);
         end else if (!w_store && w_deq) begin
            r_count <= r_count - CNT_WIDTH'(1);
         end
      end
   end

`ifdef W2I_BYPASS_EN
   logic                   w_rs1_hit;
   logic [`DATA_WIDTH-1:0] w_rs1_data;
   logic                   w_rs2_hit;
   logic [`DATA_WIDTH-1:0] w_rs2_data;
   logic [PTR_W-1:0]       w_idx;

   // Walk oldest to youngest so the youngest match is the one left standing
   always_comb begin
      w_rs1_hit  = 1'b0;
      w_rs1_data = `DATA_ZERO;
      w_rs2_hit  = 1'b0;
      w_rs2_data = `DATA_ZERO;
      w_idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_rptr + PTR_W'(k);
         if (CNT_WIDTH'(k) < r_count) begin
            if ((bus.i_idu_rs1_id != '0) && (r_rd[w_idx] == bus.i_idu_rs1_id)) begin
               w_rs1_hit  = 1'b1;
               w_rs1_data = r_data[w_idx];
            end
            if ((bus.i_idu_rs2_id != '0) && (r_rd[w_idx] == bus.i_idu_rs2_id)) begin
               w_rs2_hit  = 1'b1;
               w_rs2_data = r_data[w_idx];
            end
         end
      end
   end

   assign bus.o_w2i_rs1_hit  = w_rs1_hit;
   assign bus.o_w2i_rs1_data = w_rs1_data;
   assign bus.o_w2i_rs2_hit  = w_rs2_hit;
   assign bus.o_w2i_rs2_data = w_rs2_data;
`else
   logic w_unused_rs_ids;

   assign w_unused_rs_ids    = ^{bus.i_idu_rs1_id, bus.i_idu_rs2_id};
   assign bus.o_w2i_rs1_hit  = 1'b0;
   assign bus.o_w2i_rs1_data = `DATA_ZERO;
   assign bus.o_w2i_rs2_hit  = 1'b0;
   assign bus.o_w2i_rs2_data = `DATA_ZERO;
`endif

endmodule

// File: tb/tb_wbu2idu.sv
// Self-checking bench for wbu2idu: directed steps plus random traffic against a queue model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_INIT
`define ADDR_INIT 32'h8000_0000
`endif
`ifndef DATA_ZERO
`define DATA_ZERO 32'h0000_0000
`endif

module tb_wbu2idu;
   localparam int unsigned DEPTH     = 2;
   localparam int unsigned CNT_WIDTH = $clog2(DEPTH) + 1;

   typedef struct {
      logic [`ADDR_WIDTH-1:0] pc;
      logic [`GPRS_WIDTH-1:0] rd;
      logic [`DATA_WIDTH-1:0] data;
   } ent_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   bit   mon_en;
   ent_t q[$];

   wbu2idu_if #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

   wbu2idu #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .i_sys_clk   (clk),
      .i_sys_rst_n (rst_n),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic en,
                        input logic [4:0] rd, input logic [31:0] d, input logic rdy);
      bus.i_wbu_valid       = v;
      bus.i_wbu_pc          = pc;
      bus.i_wbu_gpr_wr_en   = en;
      bus.i_wbu_gpr_rd_id   = rd;
      bus.i_wbu_gpr_wr_data = d;
      bus.i_idu_ready       = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bypass reference: youngest matching buffered entry wins, id 0 never hits
   task automatic bypass_ref(input logic [4:0] id, output logic hit, output logic [31:0] data);
      hit  = 1'b0;
      data = `DATA_ZERO;
`ifdef W2I_BYPASS_EN
      for (int i = 0; i < q.size(); i++) begin
         if (id != 5'd0 && q[i].rd == id) begin
            hit  = 1'b1;
            data = q[i].data;
         end
      end
`endif
   endtask

   // Compare against the model mid-cycle, then advance the model by what the next edge does
   always @(negedge clk) begin
      if (mon_en) begin
         int          n;
         logic        h;
         logic [31:0] d;
         bit          do_pop;
         bit          do_push;
         n = q.size();
         check("ready", 64'(bus.o_w2i_ready), 64'(n < DEPTH));
         check("valid", 64'(bus.o_w2i_valid), 64'(n != 0));
         check("count", 64'(bus.o_w2i_count), 64'(n));
         if (n != 0) begin
            check("head_pc",   64'(bus.o_w2i_pc),          64'(q[0].pc));
            check("head_rd",   64'(bus.o_w2i_gpr_rd_id),   64'(q[0].rd));
            check("head_data", 64'(bus.o_w2i_gpr_wr_data), 64'(q[0].data));
            check("head_wren", 64'(bus.o_w2i_gpr_wr_en),   64'(1));
         end
         bypass_ref(bus.i_idu_rs1_id, h, d);
         check("rs1_hit",  64'(bus.o_w2i_rs1_hit),  64'(h));
         check("rs1_data", 64'(bus.o_w2i_rs1_data), 64'(d));
         bypass_ref(bus.i_idu_rs2_id, h, d);
         check("rs2_hit",  64'(bus.o_w2i_rs2_hit),  64'(h));
         check("rs2_data", 64'(bus.o_w2i_rs2_data), 64'(d));
         do_pop  = (n != 0) && bus.i_idu_ready;
         do_push = bus.i_wbu_valid && (n < DEPTH) && bus.i_wbu_gpr_wr_en
                   && (bus.i_wbu_gpr_rd_id != 5'd0);
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back('{pc: bus.i_wbu_pc, rd: bus.i_wbu_gpr_rd_id,
                                     data: bus.i_wbu_gpr_wr_data});
      end
   end

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_ready"}, 64'(bus.o_w2i_ready),       64'(0));
      check({pfx, "_valid"}, 64'(bus.o_w2i_valid),       64'(0));
      check({pfx, "_count"}, 64'(bus.o_w2i_count),       64'(0));
      check({pfx, "_pc"},    64'(bus.o_w2i_pc),          64'(`ADDR_INIT));
      check({pfx, "_rd"},    64'(bus.o_w2i_gpr_rd_id),   64'(0));
      check({pfx, "_data"},  64'(bus.o_w2i_gpr_wr_data), 64'(`DATA_ZERO));
      check({pfx, "_wren"},  64'(bus.o_w2i_gpr_wr_en),   64'(0));
      check({pfx, "_hit1"},  64'(bus.o_w2i_rs1_hit),     64'(0));
      check({pfx, "_hit2"},  64'(bus.o_w2i_rs2_hit),     64'(0));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      mon_en   = 1'b0;
      rst_n    = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      bus.i_idu_rs1_id = 5'd0;
      bus.i_idu_rs2_id = 5'd0;

      // Reset held, then idle after release
      tick();
      tick();
      check_reset_outputs("rst");
      rst_n  = 1'b1;
      mon_en = 1'b1;
      #4;
      check("idle_ready", 64'(bus.o_w2i_ready), 64'(1));
      check("idle_pc",    64'(bus.o_w2i_pc),    64'(`ADDR_INIT));
      tick();

      // Single write, stalled 3 cycles, then drained
      drive(1'b1, 32'h8000_0000, 1'b1, 5'd5, 32'h1234, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      repeat (3) tick();
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
      tick();
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      tick();
      check("drained_count", 64'(bus.o_w2i_count), 64'(0));

      // Fill, hold a blocked request while full, then alternate dequeue / enqueue
      drive(1'b1, 32'h100, 1'b1, 5'd3, 32'hA, 1'b0);
      tick();
      drive(1'b1, 32'h104, 1'b1, 5'd4, 32'hB, 1'b0);
      tick();
      drive(1'b1, 32'h108, 1'b1, 5'd6, 32'hC, 1'b0);
      tick();
      check("full_ready", 64'(bus.o_w2i_ready), 64'(0));
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
      tick();
      drive(1'b1, 32'h108, 1'b1, 5'd6, 32'hC, 1'b0);
      tick();
      drive(1'b1, 32'h10C, 1'b1, 5'd7, 32'hD, 1'b1);
      tick();
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
      repeat (3) tick();

      // Filtered requests complete but store nothing
      drive(1'b1, 32'h200, 1'b1, 5'd0, 32'hFFFF, 1'b0);
      tick();
      drive(1'b1, 32'h204, 1'b0, 5'd7, 32'h5555, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      tick();
      check("filter_count", 64'(bus.o_w2i_count), 64'(0));

      // Bypass: two writes to x9, youngest data must win
      bus.i_idu_rs1_id = 5'd9;
      bus.i_idu_rs2_id = 5'd0;
      drive(1'b1, 32'h300, 1'b1, 5'd9, 32'h11, 1'b0);
      tick();
      drive(1'b1, 32'h304, 1'b1, 5'd9, 32'h22, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      tick();
`ifdef W2I_BYPASS_EN
      check("byp_rs1_hit",  64'(bus.o_w2i_rs1_hit),  64'(1));
      check("byp_rs1_data", 64'(bus.o_w2i_rs1_data), 64'(32'h22));
`else
      check("byp_rs1_hit",  64'(bus.o_w2i_rs1_hit),  64'(0));
      check("byp_rs1_data", 64'(bus.o_w2i_rs1_data), 64'(0));
`endif
      check("byp_rs2_hit", 64'(bus.o_w2i_rs2_hit), 64'(0));
      check("pre_rst_count", 64'(bus.o_w2i_count), 64'(2));

      // Asynchronous reset mid-stream with two entries buffered
      #1;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check_reset_outputs("async");
      q.delete();
      tick();
      rst_n  = 1'b1;
      mon_en = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
      repeat (3) tick();

      // Random traffic against the model
      for (int c = 0; c < 400; c++) begin
         drive(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 3) != 0),
               5'($urandom_range(0, 7)), $urandom(), 1'($urandom_range(0, 1)));
         bus.i_idu_rs1_id = 5'($urandom_range(0, 7));
         bus.i_idu_rs2_id = 5'($urandom_range(0, 7));
         tick();
      end
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
      repeat (4) tick();
      check("final_count", 64'(bus.o_w2i_count), 64'(0));

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
